pipe_stage_skid_reg: RTL and testbench
======================================

# pipe_stage_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It decouples adjacent stages of the 6-stage core so that a downstream stall no longer has to be broadcast combinationally as a global enable. It supports a full flush and a selective flush that kills only speculative entries. It carries a generic payload plus control field, a speculation tag, and an optional stall/flush performance counter pair.

## Interface

Parameters:

- PAYLOAD_W, 96, width of the data payload (PC, next-PC, instruction, operands packed by the instantiating stage)
- CTRL_W, 10, width of the control field; cleared to 0 on reset and on flush so a killed slot is inert
- CNT_W, 16, width of each performance counter

Ports:

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; equals NOT skid-slot valid (registered, no combinational path from out_ready)
- in_payload  input  PAYLOAD_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control bits
- in_spec  input  1  entry fetched under branch speculation
- flush  input  1  kill every held entry and the incoming one
- flush_spec  input  1  kill only entries with spec=1 (held and incoming)
- out_valid  output  1  main slot valid
- out_ready  input  1  downstream accepts
- out_payload  output  PAYLOAD_W  main-slot payload
- out_ctrl  output  CTRL_W  main-slot control
- out_spec  output  1  main-slot speculation tag
- occupancy  output  2  entries held: 0, 1 or 2
- stall_cnt  output  CNT_W  present only with PIPE_STAGE_PERF_CNT_EN
- flush_cnt  output  CNT_W  present only with PIPE_STAGE_PERF_CNT_EN

## Operation

- Two slots: M (main, drives outputs) and S (skid). Accept = in_valid & in_ready. Release = out_valid & out_ready.
- States:
  - EMPTY (M and S invalid)
  - ONE (M valid)
  - FULL (M and S valid)
- Transitions with no flush:
  - EMPTY: accept -> ONE, M <= in.
  - ONE:
    - accept & release -> ONE, M <= in.
    - accept only -> FULL, S <= in.
    - release only -> EMPTY.
    - neither -> hold.
  - FULL: in_ready=0.
    - release -> ONE, M <= S.
    - else hold.
- flush (priority over everything):
  - Next state is EMPTY.
  - The incoming entry is dropped.
  - M and S ctrl and spec are cleared.
  - Payload does not care, and is held.
- flush_spec (ignored when flush=1):
  - Every slot with spec=1 is invalidated, and its ctrl is cleared.
  - An incoming entry with in_spec=1 is dropped.
  - The survivors are compacted in order: old M, then old S, then the incoming entry.
  - Compaction happens after the release of M this cycle is applied.
  - Example: M spec, S non-spec, no release -> ONE with M <= old S.
- Order is always preserved. Each entry is delivered exactly once.
- out_valid = M valid. out_payload, out_ctrl and out_spec are direct register outputs.
- Reset (rst=0, asynchronous):
  - State is EMPTY.
  - out_valid=0, out_payload=0, out_ctrl=0, out_spec=0, occupancy=0.
  - in_ready=0 while rst=0, and 1 from the first edge after release.
  - Both counters are 0.
  - Reset mid-transfer discards all held entries.

## Timing

- Latency: accept at edge N -> out_valid at N+1, provided the stage was EMPTY, or was ONE and releasing.
- Throughput: one entry per cycle while out_ready=1.
- After out_ready drops, one further entry is absorbed into S. in_ready falls the following cycle.
- in_ready is a function of register state only.
- flush and flush_spec take effect at the same edge they are sampled. Outputs are killed in the next cycle.
- occupancy is updated at the same edge as the slots.

## Configuration

- PIPE_STAGE_PERF_CNT_EN defined:
  - stall_cnt increments every cycle with out_valid=1 and out_ready=0.
  - flush_cnt increments every cycle in which flush or flush_spec invalidates at least one held or incoming entry.
  - Both counters saturate at all-ones and never wrap.
- Not defined: the counters and their ports are absent, and there is no logic for them.

## Test plan

- Streaming:
  - Stimulus: 8 entries with payload 0x10..0x17, in_valid=1, out_ready=1 continuously.
  - Required: outputs 0x10..0x17 on consecutive cycles, 1 cycle after input; occupancy stays 1; in_ready stays 1.
- Skid:
  - Stimulus: stream 0xA1, 0xA2, 0xA3; drop out_ready after 0xA1 is shown.
  - Required: 0xA2 is held in S, occupancy=2, in_ready=0, and 0xA3 is not taken.
  - Then raise out_ready: order 0xA1, 0xA2, 0xA3 with no loss or duplication.
- Full flush:
  - Stimulus: assert flush in FULL with in_valid=1.
  - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, and the incoming entry never appears.
- Selective flush:
  - Stimulus: M spec=1 (0xB1), S spec=0 (0xB2), incoming spec=1 (0xB3); assert flush_spec.
  - Required: next cycle M=0xB2 with out_valid=1, occupancy=1; 0xB1 and 0xB3 never appear.
- Reset mid-operation:
  - Stimulus: pull rst low asynchronously while FULL.
  - Required: outputs are 0 immediately and in_ready=0; after release, in_ready=1 at the first edge.
- Counters (macro on, CNT_W=4):
  - Stimulus: hold out_valid=1 and out_ready=0 for 20 cycles.
  - Required: stall_cnt=15, saturated.
  - Stimulus: one flush with occupancy=0 and in_valid=0.
  - Required: flush_cnt unchanged.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// pipe_stage_skid_reg: valid/ready pipeline register with a two-entry skid buffer,
// full and speculative flush. Optional stall/flush counters with PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_skid_reg #(
  parameter int PAYLOAD_W = 96,
  parameter int CTRL_W    = 10,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic                 in_spec,
  input  logic                 flush,
  input  logic                 flush_spec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic                 out_spec,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 rdy_q;
  logic [PAYLOAD_W-1:0] m_payload_q, m_payload_d;
  logic [CTRL_W-1:0]    m_ctrl_q, m_ctrl_d;
  logic                 m_spec_q, m_spec_d;
  logic [PAYLOAD_W-1:0] s_payload_q, s_payload_d;
  logic [CTRL_W-1:0]    s_ctrl_q, s_ctrl_d;
  logic                 s_spec_q, s_spec_d;

  logic w_m_valid;
  logic w_s_valid;
  logic w_accept;
  logic w_release;
  logic w_m_keep;
  logic w_s_keep;
  logic w_in_keep;

  assign w_m_valid = (state_q != EMPTY);
  assign w_s_valid = (state_q == FULL);
  assign w_accept  = in_valid & rdy_q;
  assign w_release = w_m_valid & out_ready;

  // Survivors after this cycle's release and speculative kill, in delivery order.
  assign w_m_keep  = w_m_valid & ~w_release & ~(flush_spec & m_spec_q);
  assign w_s_keep  = w_s_valid & ~(flush_spec & s_spec_q);
  assign w_in_keep = w_accept & ~(flush_spec & in_spec);

  always_comb begin
    state_d     = state_q;
    m_payload_d = m_payload_q;
    m_ctrl_d    = m_ctrl_q;
    m_spec_d    = m_spec_q;
    s_payload_d = s_payload_q;
    s_ctrl_d    = s_ctrl_q;
    s_spec_d    = s_spec_q;

    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      m_spec_d = 1'b0;
      s_ctrl_d = '0;
      s_spec_d = 1'b0;
    end else begin
      case ({w_m_keep, w_s_keep, w_in_keep})
        3'b001: begin
          state_d     = ONE;
          m_payload_d = in_payload;
          m_ctrl_d    = in_ctrl;
          m_spec_d    = in_spec;
        end
        3'b010: begin
          state_d     = ONE;
          m_payload_d = s_payload_q;
          m_ctrl_d    = s_ctrl_q;
          m_spec_d    = s_spec_q;
        end
        3'b011: begin
          state_d     = FULL;
          m_payload_d = s_payload_q;
          m_ctrl_d    = s_ctrl_q;
          m_spec_d    = s_spec_q;
          s_payload_d = in_payload;
          s_ctrl_d    = in_ctrl;
          s_spec_d    = in_spec;
        end
        3'b100: begin
          state_d = ONE;
        end
        3'b101: begin
          state_d     = FULL;
          s_payload_d = in_payload;
          s_ctrl_d    = in_ctrl;
          s_spec_d    = in_spec;
        end
        3'b110, 3'b111: begin
          state_d = FULL;
        end
        default: begin
          state_d = EMPTY;
        end
      endcase

      // Slots vacated by a speculative kill are made inert.
      if (flush_spec) begin
        if (state_d == EMPTY) begin
          m_ctrl_d = '0;
          m_spec_d = 1'b0;
        end
        if (state_d != FULL) begin
          s_ctrl_d = '0;
          s_spec_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      rdy_q       <= 1'b0;
      m_payload_q <= '0;
      m_ctrl_q    <= '0;
      m_spec_q    <= 1'b0;
      s_payload_q <= '0;
      s_ctrl_q    <= '0;
      s_spec_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= (state_d != FULL);
      m_payload_q <= m_payload_d;
      m_ctrl_q    <= m_ctrl_d;
      m_spec_q    <= m_spec_d;
      s_payload_q <= s_payload_d;
      s_ctrl_q    <= s_ctrl_d;
      s_spec_q    <= s_spec_d;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready    = rdy_q;
  assign out_valid   = w_m_valid;
  assign out_payload = m_payload_q;
  assign out_ctrl    = m_ctrl_q;
  assign out_spec    = m_spec_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             w_stall_hit;
  logic             w_flush_hit;

  assign w_stall_hit = w_m_valid & ~out_ready;
  assign w_flush_hit = flush ? (w_m_valid | w_accept)
                             : (flush_spec & ((w_m_valid & ~w_release & m_spec_q) |
                                              (w_s_valid & s_spec_q) |
                                              (w_accept & in_spec)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_stall_hit && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_flush_hit && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = |CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// tb_pipe_stage_skid_reg: directed scenarios plus randomized traffic checked against a queue model.
module tb_pipe_stage_skid_reg;
  localparam int PW = 96;
  localparam int CW = 10;
  localparam int NW = 4;
  localparam int CMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, in_spec, flush, flush_spec;
  logic          out_valid, out_ready, out_spec;
  logic [PW-1:0] in_payload, out_payload;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [NW-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_ctrl(in_ctrl), .in_spec(in_spec), .flush(flush), .flush_spec(flush_spec),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_ctrl(out_ctrl), .out_spec(out_spec), .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: an ordered list of held entries, head is what must be on the outputs.
  typedef struct {
    logic [PW-1:0] payload;
    logic [CW-1:0] ctrl;
    logic          spec;
  } ent_t;

  ent_t q[$];
  bit   m_rdy = 1'b0;
  bit   m_ctrl0 = 1'b1;
  int   m_stall = 0;
  int   m_flush = 0;

  always @(posedge clk or negedge rst) begin : model
    ent_t nq[$];
    ent_t e;
    bit   acc, rel, killed, mkill;
    if (!rst) begin
      q.delete();
      m_rdy   = 1'b0;
      m_ctrl0 = 1'b1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      acc    = in_valid && m_rdy;
      rel    = (q.size() > 0) && out_ready;
      killed = 1'b0;
      mkill  = flush_spec && (q.size() > 0) && q[0].spec && !rel;
      if ((q.size() > 0) && !out_ready && (m_stall < CMAX)) m_stall++;
      if (flush) begin
        killed  = (q.size() > 0) || acc;
        q.delete();
        m_ctrl0 = 1'b1;
      end else begin
        if (rel) void'(q.pop_front());
        if (flush_spec) begin
          nq.delete();
          foreach (q[i]) begin
            if (q[i].spec) killed = 1'b1;
            else nq.push_back(q[i]);
          end
          q = nq;
          if (acc && in_spec) killed = 1'b1;
        end
        if (acc && !(flush_spec && in_spec)) begin
          e.payload = in_payload;
          e.ctrl    = in_ctrl;
          e.spec    = in_spec;
          q.push_back(e);
        end
        m_ctrl0 = mkill && (q.size() == 0);
      end
      if (killed && (m_flush < CMAX)) m_flush++;
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", in_ready, m_rdy);
      check("occupancy", occupancy, q.size());
      check("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("out_payload", out_payload, q[0].payload);
        check("out_ctrl", out_ctrl, q[0].ctrl);
        check("out_spec", out_spec, q[0].spec);
      end else if (m_ctrl0) begin
        check("killed_ctrl", out_ctrl, 0);
        check("killed_spec", out_spec, 0);
      end
`ifdef PIPE_STAGE_PERF_CNT_EN
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
`endif
    end
  end

  task automatic drive(input bit v, input logic [PW-1:0] p, input logic [CW-1:0] c,
                       input bit s, input bit ordy, input bit fl, input bit fs);
    in_valid   = v;
    in_payload = p;
    in_ctrl    = c;
    in_spec    = s;
    out_ready  = ordy;
    flush      = fl;
    flush_spec = fs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, '0, '0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #11;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_payload", out_payload, 0);
    rst = 1'b1;
    #1 check("rel_in_ready_before_edge", in_ready, 0);
    tick();
    check("rel_in_ready_first_edge", in_ready, 1);

    // Streaming at full throughput
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1, 96'h10 + i, CW'(i + 1), 0, 1, 0, 0);
      else       drive(0, '0, '0, 0, 1, 0, 0);
      @(negedge clk);
      if (i > 0) begin
        check("stream_valid", out_valid, 1);
        check("stream_data", out_payload, 96'h10 + i - 1);
        check("stream_occ", occupancy, 1);
      end
      check("stream_rdy", in_ready, 1);
      tick();
    end
    drive(0, '0, '0, 0, 1, 0, 0);
    tick();

    // Skid absorption
    drive(1, 96'hA1, 10'h1, 0, 1, 0, 0); tick();
    drive(1, 96'hA2, 10'h2, 0, 0, 0, 0);
    @(negedge clk); check("skid_a1", out_payload, 96'hA1);
    tick();
    drive(1, 96'hA3, 10'h3, 0, 0, 0, 0);
    @(negedge clk);
    check("skid_occ2", occupancy, 2);
    check("skid_rdy0", in_ready, 0);
    check("skid_hold_a1", out_payload, 96'hA1);
    tick();
    drive(1, 96'hA3, 10'h3, 0, 1, 0, 0);
    @(negedge clk); check("skid_still_full", occupancy, 2);
    tick();
    @(negedge clk);
    check("skid_a2", out_payload, 96'hA2);
    check("skid_rdy1", in_ready, 1);
    tick();
    drive(0, '0, '0, 0, 1, 0, 0);
    @(negedge clk);
    check("skid_a3", out_payload, 96'hA3);
    check("skid_occ1", occupancy, 1);
    tick();
    @(negedge clk); check("skid_drained", out_valid, 0);
    tick();

    // Full flush from FULL with an incoming entry
    drive(1, 96'hC1, 10'h3FF, 0, 0, 0, 0); tick();
    drive(1, 96'hC2, 10'h3FF, 1, 0, 0, 0); tick();
    drive(1, 96'hC3, 10'h3FF, 0, 0, 1, 0);
    @(negedge clk); check("flush_pre_occ", occupancy, 2);
    tick();
    drive(0, '0, '0, 0, 1, 0, 0);
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_occ", occupancy, 0);
    tick();
    @(negedge clk); check("flush_no_c3", out_valid, 0);
    tick();

    // Selective flush: spec head, non-spec skid, spec incoming
    drive(1, 96'hB1, 10'h11, 1, 0, 0, 0); tick();
    drive(1, 96'hB2, 10'h22, 0, 0, 0, 0); tick();
    drive(1, 96'hB3, 10'h33, 1, 0, 0, 1); tick();
    drive(0, '0, '0, 0, 1, 0, 0);
    @(negedge clk);
    check("sflush_valid", out_valid, 1);
    check("sflush_b2", out_payload, 96'hB2);
    check("sflush_occ", occupancy, 1);
    tick();
    @(negedge clk); check("sflush_no_b3", out_valid, 0);
    tick();

    // Asynchronous reset while FULL
    drive(1, 96'hD1, 10'h5, 0, 0, 0, 0); tick();
    drive(1, 96'hD2, 10'h6, 0, 0, 0, 0); tick();
    drive(0, '0, '0, 0, 0, 0, 0);
    @(negedge clk); check("rstmid_full", occupancy, 2);
    #2 rst = 1'b0;
    #1;
    check("rstmid_valid", out_valid, 0);
    check("rstmid_payload", out_payload, 0);
    check("rstmid_ctrl", out_ctrl, 0);
    check("rstmid_spec", out_spec, 0);
    check("rstmid_occ", occupancy, 0);
    check("rstmid_rdy", in_ready, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    check("rstmid_rdy_low", in_ready, 0);
    tick();
    check("rstmid_rdy_first_edge", in_ready, 1);
    check("rstmid_occ_after", occupancy, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, CW'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) == 0));
      tick();
    end
    drive(0, '0, '0, 0, 1, 0, 0);
    tick();
    tick();

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Counter saturation and no-op flush
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    drive(1, 96'hE1, 10'h7, 0, 0, 0, 0); tick();
    drive(0, '0, '0, 0, 0, 0, 0);
    repeat (20) tick();
    @(negedge clk); check("stall_saturated", stall_cnt, 15);
    drive(0, '0, '0, 0, 1, 0, 0); tick();
    tick();
    drive(0, '0, '0, 0, 1, 1, 0); tick();
    drive(0, '0, '0, 0, 1, 0, 0);
    @(negedge clk); check("flush_cnt_empty", flush_cnt, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
